// File: rtl/pipe_pkg.sv
// Shared types and constants for the instruction fetch path.
package pipe_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FETCH   = 2'd1,
      HOLD    = 2'd2,
      DISCARD = 2'd3
   } fetch_state_e;

   localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
   localparam int          INSTR_BYTES  = 4;
   localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/imem_fetch_ctrl_if.sv
// Request/ready bus between the fetch sequencer and instruction memory.
interface imem_fetch_ctrl_if #(
   parameter int AW = 32
) ();
   logic          mem_req;
   logic [AW-1:0] mem_addr;
   logic          mem_ready;
   logic [31:0]   mem_rdata;

   modport master (output mem_req, output mem_addr, input mem_ready, input mem_rdata);
   modport slave  (input mem_req, input mem_addr, output mem_ready, output mem_rdata);
endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of {pc, instr}; push and pop may coincide even when full.
module fetch_fifo
   import pipe_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int AW    = 32,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          flush,
   input  logic          push,
   input  logic          pop,
   input  logic [AW-1:0] push_pc,
   input  logic [31:0]   push_instr,
   output logic [AW-1:0] head_pc,
   output logic [31:0]   head_instr,
   output logic [CW-1:0] count,
   output logic          empty
);
   localparam int PW = $clog2(DEPTH);

   logic [AW-1:0] pc_mem  [DEPTH];
   logic [31:0]   ins_mem [DEPTH];
   logic [PW-1:0] rd_ptr, wr_ptr;
   logic [AW-1:0] last_pc;
   logic [31:0]   last_instr;
   logic          do_push, do_pop;

   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && ((count < CW'(DEPTH)) || do_pop);

   // An empty buffer keeps presenting the last head so the outputs never go X.
   assign head_pc    = empty ? last_pc    : pc_mem[rd_ptr];
   assign head_instr = empty ? last_instr : ins_mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push && !flush && !reset) begin
         pc_mem[wr_ptr]  <= push_pc;
         ins_mem[wr_ptr] <= push_instr;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
         last_pc    <= '0;
         last_instr <= NOP_INSTR;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         if (!empty) begin
            last_pc    <= head_pc;
            last_instr <= head_instr;
         end
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop) begin
            rd_ptr     <= rd_ptr + PW'(1);
            last_pc    <= head_pc;
            last_instr <= head_instr;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer: word-aligned requests to instruction memory, buffered delivery to IF/ID.
//
// state   | meaning
// IDLE    | one cycle after reset before the first request
// FETCH   | request outstanding at fetch_pc
// HOLD    | buffer full, no request
// DISCARD | redirect arrived mid-request; finish it, drop data, then go to target
module imem_fetch_ctrl
   import pipe_pkg::*;
#(
   parameter int          AW       = 32,
   parameter logic [AW-1:0] RESET_PC = AW'(DEF_RESET_PC),
   parameter int          DEPTH    = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                stall,
   input  logic                redirect_valid,
   input  logic [AW-1:0]       redirect_pc,
   imem_fetch_ctrl_if.master   mem,
   output logic                if_valid,
   output logic [AW-1:0]       if_pc,
   output logic [31:0]         if_instr,
   output logic [31:0]         fetch_count
);
   localparam int CW = $clog2(DEPTH) + 1;

   fetch_state_e  state_q, state_d;
   logic [AW-1:0] fetch_pc_q, fetch_pc_d;
   logic [AW-1:0] tgt_q, tgt_d;
   logic [AW-1:0] tgt_aligned;
   logic [CW-1:0] count;
   logic          empty, push, pop;

   assign tgt_aligned  = redirect_pc & ~AW'(3);
   assign if_valid     = !empty;
   // A redirect in the same cycle suppresses delivery of the old stream.
   assign pop          = if_valid && !stall && !redirect_valid;
   assign mem.mem_req  = (state_q == FETCH) || (state_q == DISCARD);
   assign mem.mem_addr = fetch_pc_q;

   fetch_fifo #(.DEPTH(DEPTH), .AW(AW), .CW(CW)) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .flush      (redirect_valid),
      .push       (push),
      .pop        (pop),
      .push_pc    (fetch_pc_q),
      .push_instr (mem.mem_rdata),
      .head_pc    (if_pc),
      .head_instr (if_instr),
      .count      (count),
      .empty      (empty)
   );

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      tgt_d      = tgt_q;
      push       = 1'b0;
      case (state_q)
         IDLE: begin
            state_d = FETCH;
            if (redirect_valid) fetch_pc_d = tgt_aligned;
         end
         FETCH: begin
            if (redirect_valid) begin
               if (mem.mem_ready) begin
                  fetch_pc_d = tgt_aligned;
               end else begin
                  tgt_d   = tgt_aligned;
                  state_d = DISCARD;
               end
            end else if (mem.mem_ready) begin
               push       = 1'b1;
               fetch_pc_d = fetch_pc_q + AW'(INSTR_BYTES);
               if ((count == CW'(DEPTH - 1)) && !pop) state_d = HOLD;
            end
         end
         HOLD: begin
            if (redirect_valid) begin
               fetch_pc_d = tgt_aligned;
               state_d    = FETCH;
            end else if (pop) begin
               state_d = FETCH;
            end
         end
         DISCARD: begin
            if (redirect_valid) begin
               tgt_d = tgt_aligned;
            end else if (mem.mem_ready) begin
               fetch_pc_d = tgt_q;
               state_d    = FETCH;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         fetch_pc_q  <= RESET_PC;
         tgt_q       <= RESET_PC;
         fetch_count <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         tgt_q      <= tgt_d;
         if (pop) fetch_count <= fetch_count + 32'd1;
      end
   end
endmodule
